// File: rtl/ei_axi_wr_arbiter.sv
// ei_axi_wr_arbiter
//   Round-robin arbiter that shares one AXI write path (AW + W) among
//   NUM_MASTERS ei_axi masters in front of a single slave port. The grant is
//   held from the AW handshake until the last W beat, so bursts never
//   interleave. The burst end is always taken from a beat counter.
//
// Ports
//   ACLK, ARESETn       clock (rising edge), asynchronous active-low reset
//   M_AW*, M_W*         packed per-master AW/W channels, master i at slice i
//   M_AWREADY/M_WREADY  per-master readies; only the granted master sees one
//   S_AW*, S_W*         forwarded AW/W channel toward the slave
//   GRANT               index of the current owner
//   GRANT_VALID         high while a burst owns the path (ADDR and DATA)
//   ERR_WLAST           one-cycle pulse on a master WLAST mismatch
//
// Build option
//   EI_AXI_ARB_WLAST_GEN_EN  when defined, S_WLAST is regenerated from the
//   beat counter and ERR_WLAST flags masters whose WLAST disagrees; otherwise
//   the master's WLAST is passed through and ERR_WLAST is tied low.
module ei_axi_wr_arbiter #(
  parameter int NUM_MASTERS  = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int ADRESS_WIDTH = 32,
  localparam int GW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                               ACLK,
  input  logic                               ARESETn,
  input  logic [NUM_MASTERS*ADRESS_WIDTH-1:0] M_AWADDR,
  input  logic [NUM_MASTERS*4-1:0]           M_AWLEN,
  input  logic [NUM_MASTERS*3-1:0]           M_AWSIZE,
  input  logic [NUM_MASTERS*2-1:0]           M_AWBURST,
  input  logic [NUM_MASTERS-1:0]             M_AWVALID,
  output logic [NUM_MASTERS-1:0]             M_AWREADY,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]  M_WDATA,
  input  logic [NUM_MASTERS-1:0]             M_WLAST,
  input  logic [NUM_MASTERS-1:0]             M_WVALID,
  output logic [NUM_MASTERS-1:0]             M_WREADY,
  output logic [ADRESS_WIDTH-1:0]            S_AWADDR,
  output logic [3:0]                         S_AWLEN,
  output logic [2:0]                         S_AWSIZE,
  output logic [1:0]                         S_AWBURST,
  output logic                               S_AWVALID,
  input  logic                               S_AWREADY,
  output logic [DATA_WIDTH-1:0]              S_WDATA,
  output logic                               S_WLAST,
  output logic                               S_WVALID,
  input  logic                               S_WREADY,
  output logic [GW-1:0]                      GRANT,
  output logic                               GRANT_VALID,
  output logic                               ERR_WLAST
);

  localparam int NM = NUM_MASTERS;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [3:0]    beat_cnt;
  logic [3:0]    len_q;

  logic [2*NM-1:0] req_dbl;
  logic [NM-1:0]   req_rot;
  logic [GW-1:0]   off;
  logic [GW:0]     pick_sum;
  logic [GW-1:0]   pick;
  logic            aw_hs;
  logic            w_hs;
  logic            last_beat;

  // Rotate the request vector so bit 0 is the master at rr_ptr; the lowest
  // set bit of the rotated vector is then the round-robin winner's offset.
  assign req_dbl = {M_AWVALID, M_AWVALID} >> rr_ptr;
  assign req_rot = req_dbl[NM-1:0];

  always_comb begin
    off = '0;
    for (int unsigned k = NM; k > 0; k--) begin
      if (req_rot[k-1]) off = GW'(k - 1);
    end
    pick_sum = {1'b0, rr_ptr} + {1'b0, off};
    if (pick_sum >= (GW+1)'(NM)) pick_sum = pick_sum - (GW+1)'(NM);
    pick = pick_sum[GW-1:0];
  end

  assign aw_hs     = (state == ADDR) && M_AWVALID[GRANT] && S_AWREADY;
  assign w_hs      = (state == DATA) && M_WVALID[GRANT] && S_WREADY;
  assign last_beat = (beat_cnt == len_q);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      GRANT    <= '0;
      beat_cnt <= '0;
      len_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|M_AWVALID) begin
            GRANT <= pick;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (aw_hs) begin
            len_q    <= M_AWLEN[GRANT*4 +: 4];
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            if (last_beat) begin
              state    <= IDLE;
              beat_cnt <= '0;
              // The master that just finished drops to lowest priority.
              if (GRANT == GW'(NM - 1)) rr_ptr <= '0;
              else                      rr_ptr <= GRANT + 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    M_AWREADY   = '0;
    M_WREADY    = '0;
    S_AWADDR    = '0;
    S_AWLEN     = '0;
    S_AWSIZE    = '0;
    S_AWBURST   = '0;
    S_AWVALID   = 1'b0;
    S_WDATA     = '0;
    S_WLAST     = 1'b0;
    S_WVALID    = 1'b0;
    GRANT_VALID = (state != IDLE);
    case (state)
      ADDR: begin
        S_AWADDR         = M_AWADDR[GRANT*ADRESS_WIDTH +: ADRESS_WIDTH];
        S_AWLEN          = M_AWLEN[GRANT*4 +: 4];
        S_AWSIZE         = M_AWSIZE[GRANT*3 +: 3];
        S_AWBURST        = M_AWBURST[GRANT*2 +: 2];
        S_AWVALID        = M_AWVALID[GRANT];
        M_AWREADY[GRANT] = S_AWREADY;
      end
      DATA: begin
        S_WDATA         = M_WDATA[GRANT*DATA_WIDTH +: DATA_WIDTH];
        S_WVALID        = M_WVALID[GRANT];
        M_WREADY[GRANT] = S_WREADY;
`ifdef EI_AXI_ARB_WLAST_GEN_EN
        S_WLAST         = last_beat;
`else
        S_WLAST         = M_WLAST[GRANT];
`endif
      end
      default: ;
    endcase
  end

`ifdef EI_AXI_ARB_WLAST_GEN_EN
  assign ERR_WLAST = w_hs && (M_WLAST[GRANT] != last_beat);
`else
  assign ERR_WLAST = 1'b0;
`endif

endmodule
